register_write_arbiter: RTL and testbench
=========================================

// Module: register_write_arbiter
// PURPOSE
//  Shares one 8-bit enable-loaded register between NUM_REQ requesters using round-robin order.
//  Each requester presents req + data. The winner's data is written with a single one-cycle
//  enable pulse, then the winner receives a one-cycle ack.
//  Sits between the requesters and the register's enable/data inputs.
//  Also keeps a count of completed writes.
// PARAMETERS
//  NUM_REQ   4   number of requesters; >=2
//  DATA_W    8   register data width
//  CNT_W     16  completed-write counter width
// PORTS
//  clk        in   1                   single clock, all logic on posedge
//  rst        in   1                   synchronous, active-high reset
//  req        in   NUM_REQ             per-requester write request (level)
//  req_data   in   NUM_REQ*DATA_W      packed data; slice i belongs to req[i]
//  ack        out  NUM_REQ             one-hot, one-cycle write-complete pulse
//  reg_enable out  1                   register load enable
//  reg_data   out  DATA_W              register data input
//  grant_id   out  $clog2(NUM_REQ)     index of current/last winner
//  busy       out  1                   1 while state != IDLE
//  write_cnt  out  CNT_W               completed writes, saturating
// BEHAVIOUR
//  Interface: one clock (clk); reset is synchronous and active-high (rst).
//  Reset (rst=1 at posedge), all registered:
//   - state=IDLE; ack=0, reg_enable=0, reg_data=0, grant_id=0, busy=0, write_cnt=0.
//   - last pointer = NUM_REQ-1, so requester 0 has first priority.
//  Outputs: all outputs are flops; none are combinational from inputs.
//  FSM states:
//   - IDLE: if |req, pick winner W, latch req_data[W] into reg_data, grant_id=W, go to WRITE.
//     If no req, stay in IDLE.
//   - WRITE: reg_enable=1 for exactly this cycle (register loads at end of cycle). Go to ACK.
//   - ACK: ack[W]=1 for this cycle only; last=W; write_cnt+=1 (saturate at all-ones).
//     Go to IDLE.
//  Latency: req sampled high in IDLE at cycle t -> reg_enable in t+1 -> ack in t+2.
//   - Register holds the new value from t+2 onward.
//   - Minimum spacing between writes is 3 cycles; max throughput is 1 write per 3 cycles.
//  Round-robin pick:
//   - Search starts at (last+1) mod NUM_REQ and wraps past NUM_REQ-1 to 0.
//   - The first asserted req in that order wins.
//  Handshake:
//   - Data is captured in the IDLE cycle; later changes to req_data are ignored.
//   - A requester may drop req before ack; the write still completes and ack is still pulsed.
//   - A requester that keeps req high after its ack re-enters arbitration as a new request.
//     It is picked last if others are pending.
//  reg_data holds its last value outside WRITE; reg_enable=0 outside WRITE.
//  Reset mid-operation:
//   - Any state returns to IDLE. A pending enable or ack is never issued.
//   - The pointer returns to NUM_REQ-1.
//  write_cnt at all-ones stays all-ones. No wrap.
//  ack is always one-hot or zero.
// STRUCTURE
//  Package reg_arb_pkg holds:
//   - typedef enum logic [1:0] {IDLE, WRITE, ACK} arb_state_t;
//   - localparam DATA_W_DEF = 8.
//  Sub-module rr_arbiter (parameter NUM_REQ):
//   - Combinational round-robin pick from req + last pointer.
//   - Outputs: grant_valid, grant_idx.
//  Top level: FSM, data capture mux, write counter.
// TESTING (NUM_REQ=4, DATA_W=8)
//  1. Reset, then req=4'b0001, data0=8'hA5 -> reg_enable at t+1 with reg_data=A5; ack=0001
//     at t+2; write_cnt=1; busy high for 2 cycles.
//  2. req=4'b1111 held continuously, data_i=8'h10+i -> reg_enable order is data 10,11,12,13,10
//     (wrap); acks every 3rd cycle.
//  3. After a grant to 3, req=4'b1001 -> requester 0 wins next (wrap), then requester 3.
//  4. rst=1 during the WRITE cycle -> next cycle reg_enable=0, ack=0, busy=0, write_cnt=0;
//     a following req=0100 is granted from the pointer reset.
//  5. req0 dropped during WRITE; req_data0 changed 11->22 after IDLE -> write of 11 still
//     completes; ack[0] still pulses.
//  6. Force write_cnt near all-ones (CNT_W=4), issue 2 writes -> count ends at 4'hF.

Source files
------------

// File: rtl/reg_arb_pkg.sv
// Shared types and defaults for the register write arbiter.
package reg_arb_pkg;

  typedef enum logic [1:0] {IDLE, WRITE, ACK} arb_state_t;

  localparam int unsigned DATA_W_DEF = 8;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request after the last winner, wrapping.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last,
  output logic               grant_valid,
  output logic [IDX_W-1:0]   grant_idx
);

  int unsigned cand;

  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand        = 0;
    // Offsets 1..NUM_REQ so the previous winner is considered last.
    for (int unsigned off = 1; off <= NUM_REQ; off++) begin
      cand = (32'(last) + off) % NUM_REQ;
      if (!grant_valid && req[cand]) begin
        grant_valid = 1'b1;
        grant_idx   = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/register_write_arbiter.sv
// Round-robin arbiter sharing one enable-loaded register; IDLE -> WRITE -> ACK per write.
module register_write_arbiter
  import reg_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*DATA_W-1:0]  req_data,
  output logic [NUM_REQ-1:0]         ack,
  output logic                       reg_enable,
  output logic [DATA_W-1:0]          reg_data,
  output logic [IDX_W-1:0]           grant_id,
  output logic                       busy,
  output logic [CNT_W-1:0]           write_cnt
);

  arb_state_t          state, state_next;
  logic [IDX_W-1:0]    last, last_next;
  logic [NUM_REQ-1:0]  ack_next;
  logic                reg_enable_next;
  logic [DATA_W-1:0]   reg_data_next;
  logic [IDX_W-1:0]    grant_id_next;
  logic                busy_next;
  logic [CNT_W-1:0]    write_cnt_next;
  logic                grant_valid;
  logic [IDX_W-1:0]    grant_idx;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_arbiter (
    .req         (req),
    .last        (last),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  // State, pointer and all outputs are flops loaded from the next-state logic.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last       <= IDX_W'(NUM_REQ - 1);
      ack        <= '0;
      reg_enable <= 1'b0;
      reg_data   <= '0;
      grant_id   <= '0;
      busy       <= 1'b0;
      write_cnt  <= '0;
    end else begin
      state      <= state_next;
      last       <= last_next;
      ack        <= ack_next;
      reg_enable <= reg_enable_next;
      reg_data   <= reg_data_next;
      grant_id   <= grant_id_next;
      busy       <= busy_next;
      write_cnt  <= write_cnt_next;
    end
  end

  // Next-state logic; outputs are computed one cycle ahead so they appear with their state.
  always_comb begin
    state_next      = state;
    last_next       = last;
    ack_next        = '0;
    reg_enable_next = 1'b0;
    reg_data_next   = reg_data;
    grant_id_next   = grant_id;
    busy_next       = 1'b0;
    write_cnt_next  = write_cnt;
    case (state)
      IDLE: begin
        if (grant_valid) begin
          state_next      = WRITE;
          reg_data_next   = req_data[32'(grant_idx) * DATA_W +: DATA_W];
          grant_id_next   = grant_idx;
          reg_enable_next = 1'b1;
          busy_next       = 1'b1;
        end
      end
      WRITE: begin
        state_next          = ACK;
        busy_next           = 1'b1;
        ack_next[grant_id]  = 1'b1;
        last_next           = grant_id;
        write_cnt_next      = (&write_cnt) ? write_cnt : write_cnt + CNT_W'(1);
      end
      ACK: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_register_write_arbiter.sv
// Directed bench for register_write_arbiter (NUM_REQ=4, DATA_W=8, CNT_W=4).
module tb_register_write_arbiter;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned DATA_W  = 8;
  localparam int unsigned CNT_W   = 4;
  localparam int unsigned IDX_W   = 2;

  logic                      clk;
  logic                      rst;
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        ack;
  logic                      reg_enable;
  logic [DATA_W-1:0]         reg_data;
  logic [IDX_W-1:0]          grant_id;
  logic                      busy;
  logic [CNT_W-1:0]          write_cnt;

  int unsigned n_checks;
  int unsigned n_fails;

  register_write_arbiter #(
    .NUM_REQ (NUM_REQ),
    .DATA_W  (DATA_W),
    .CNT_W   (CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .req_data   (req_data),
    .ack        (ack),
    .reg_enable (reg_enable),
    .reg_data   (reg_data),
    .grant_id   (grant_id),
    .busy       (busy),
    .write_cnt  (write_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_data(input int unsigned i, input logic [7:0] d);
    req_data[i*DATA_W +: DATA_W] = d;
  endtask

  initial begin
    n_checks = 0;
    n_fails  = 0;
    rst      = 1'b1;
    req      = '0;
    req_data = '0;
    step();
    step();
    check("rst_ack", 32'(ack), 32'h0);
    check("rst_en", 32'(reg_enable), 32'h0);
    check("rst_data", 32'(reg_data), 32'h0);
    check("rst_gid", 32'(grant_id), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_cnt", 32'(write_cnt), 32'h0);
    rst = 1'b0;

    // 1: single write from requester 0
    req = 4'b0001;
    set_data(0, 8'hA5);
    step();
    check("t1_en", 32'(reg_enable), 32'h1);
    check("t1_data", 32'(reg_data), 32'hA5);
    check("t1_gid", 32'(grant_id), 32'h0);
    check("t1_busy_w", 32'(busy), 32'h1);
    check("t1_ack_w", 32'(ack), 32'h0);
    req = 4'b0000;
    step();
    check("t1_ack", 32'(ack), 32'h1);
    check("t1_en_off", 32'(reg_enable), 32'h0);
    check("t1_busy_a", 32'(busy), 32'h1);
    check("t1_cnt", 32'(write_cnt), 32'h1);
    step();
    check("t1_busy_i", 32'(busy), 32'h0);
    check("t1_ack_i", 32'(ack), 32'h0);
    check("t1_hold", 32'(reg_data), 32'hA5);

    // 2: all requesting continuously, rotation 0,1,2,3,0
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) set_data(i, 8'(8'h10 + i));
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      step();
      check("t2_en", 32'(reg_enable), 32'h1);
      check("t2_data", 32'(reg_data), 32'h10 + 32'(k % 4));
      step();
      check("t2_ack", 32'(ack), 32'h1 << (k % 4));
      check("t2_en_off", 32'(reg_enable), 32'h0);
      step();
      check("t2_idle", 32'(busy), 32'h0);
    end
    req = 4'b0000;
    check("t2_cnt", 32'(write_cnt), 32'h5);

    // 3: after a grant to 3, req 1001 -> 0 then 3
    req = 4'b1000;
    step();
    check("t3_g3", 32'(grant_id), 32'h3);
    step();
    check("t3_ack3", 32'(ack), 32'h8);
    req = 4'b1001;
    step();
    step();
    check("t3_first", 32'(grant_id), 32'h0);
    check("t3_first_d", 32'(reg_data), 32'h10);
    step();
    check("t3_ack0", 32'(ack), 32'h1);
    step();
    step();
    check("t3_second", 32'(grant_id), 32'h3);
    check("t3_second_d", 32'(reg_data), 32'h13);
    step();
    check("t3_ack3b", 32'(ack), 32'h8);
    req = 4'b0000;
    step();
    check("t3_cnt", 32'(write_cnt), 32'h8);

    // 4: reset during WRITE cancels the write
    req = 4'b0010;
    step();
    check("t4_en_pre", 32'(reg_enable), 32'h1);
    rst = 1'b1;
    req = 4'b0000;
    step();
    check("t4_en", 32'(reg_enable), 32'h0);
    check("t4_ack", 32'(ack), 32'h0);
    check("t4_busy", 32'(busy), 32'h0);
    check("t4_cnt", 32'(write_cnt), 32'h0);
    rst = 1'b0;
    step();
    check("t4_noack", 32'(ack), 32'h0);
    check("t4_noen", 32'(reg_enable), 32'h0);
    req = 4'b0101;
    set_data(2, 8'h5C);
    step();
    check("t4_gid", 32'(grant_id), 32'h0);
    check("t4_data", 32'(reg_data), 32'h10);
    req = 4'b0100;
    step();
    check("t4_ack0", 32'(ack), 32'h1);
    step();
    step();
    check("t4_gid2", 32'(grant_id), 32'h2);
    check("t4_data2", 32'(reg_data), 32'h5C);
    req = 4'b0000;
    step();
    check("t4_ack2", 32'(ack), 32'h4);
    check("t4_cnt2", 32'(write_cnt), 32'h2);
    step();

    // 5: req dropped and data changed after capture
    req = 4'b0001;
    set_data(0, 8'h11);
    step();
    check("t5_data", 32'(reg_data), 32'h11);
    req = 4'b0000;
    set_data(0, 8'h22);
    step();
    check("t5_ack", 32'(ack), 32'h1);
    check("t5_cnt", 32'(write_cnt), 32'h3);
    step();
    check("t5_hold", 32'(reg_data), 32'h11);
    check("t5_en", 32'(reg_enable), 32'h0);

    // 6: counter saturates at all-ones
    req = 4'b0001;
    for (int k = 0; k < 14; k++) begin
      step();
      step();
      check("t6_cnt", 32'(write_cnt), (3 + k + 1 > 15) ? 32'hF : 32'(3 + k + 1));
      step();
    end
    req = 4'b0000;
    check("t6_final", 32'(write_cnt), 32'hF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
